calc_direct_arb: RTL and testbench

Sequencer and arbiter in front of `calc_direct` in the shader. It merges two `dirpint_to_calc_direct_t` requester streams (port 0: shadow-ray results, port 1: primary-miss results) into the single `calc_direct` input using the codebase valid/stall handshake. It tracks how many rays are in flight inside `calc_direct`, and owns the `ambient` / `light_color` registers. Configuration writes are applied only once `calc_direct` has fully drained.

---
 rtl/calc_direct_arb.sv | 128 ++++++++++++
 tb/tb_calc_direct_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_direct_arb.sv
// rtl/calc_direct_arb.sv - two-port ray arbiter, in-flight tracker and drained colour config for calc_direct
// Build option: define CDARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module calc_direct_arb #(
   parameter int  INFLIGHT_W               = 5,
   parameter type dirpint_to_calc_direct_t = logic [31:0],
   parameter type float_color_t            = logic [95:0]
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req0_valid,
   input  dirpint_to_calc_direct_t req0_data,
   output logic                    req0_stall,
   input  logic                    req1_valid,
   input  dirpint_to_calc_direct_t req1_data,
   output logic                    req1_stall,
   output logic                    dirpint_to_calc_direct_valid,
   output dirpint_to_calc_direct_t dirpint_to_calc_direct_data,
   input  logic                    dirpint_to_calc_direct_stall,
   input  logic                    calc_direct_to_BM_valid,
   input  logic                    calc_direct_to_BM_stall,
   input  logic                    cfg_we,
   input  logic                    cfg_sel,
   input  float_color_t            cfg_data,
   output logic                    cfg_busy,
   output float_color_t            ambient,
   output float_color_t            light_color
);
   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, UPDATE = 2'd2} state_t;

   localparam logic [INFLIGHT_W-1:0] INFLIGHT_MAX = '1;
   localparam logic [INFLIGHT_W-1:0] INFLIGHT_ONE = INFLIGHT_W'(1);

   state_t                  state, state_nxt;
   logic                    out_valid;
   dirpint_to_calc_direct_t out_data;
   logic [INFLIGHT_W-1:0]   inflight;
   logic                    pend_sel;
   float_color_t            pend_data;
   logic                    busy;
   float_color_t            ambient_q, light_q;
   logic                    can_accept, pick0, pick1, take0, take1, out_xfer, bm_xfer;

`ifdef CDARB_RR_EN
   logic last_grant;

   // On a tie the port that did not win last time goes first.
   assign pick0 = req0_valid && (!req1_valid || last_grant);
   assign pick1 = req1_valid && (!req0_valid || !last_grant);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= 1'b1;
      end else if (take0) begin
         last_grant <= 1'b0;
      end else if (take1) begin
         last_grant <= 1'b1;
      end
   end
`else
   assign pick0 = req0_valid;
   assign pick1 = req1_valid && !req0_valid;
`endif

   assign can_accept = (state == RUN) && (!out_valid || !dirpint_to_calc_direct_stall) &&
                       (inflight != INFLIGHT_MAX);
   assign take0      = can_accept && pick0;
   assign take1      = can_accept && pick1;
   assign req0_stall = !take0;
   assign req1_stall = !take1;
   assign out_xfer   = out_valid && !dirpint_to_calc_direct_stall;
   assign bm_xfer    = calc_direct_to_BM_valid && !calc_direct_to_BM_stall;

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (cfg_we) state_nxt = DRAIN;
         DRAIN:   if (!out_valid && (inflight == '0)) state_nxt = UPDATE;
         UPDATE:  state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         out_valid <= 1'b0;
         out_data  <= '0;
         inflight  <= '0;
         pend_sel  <= 1'b0;
         pend_data <= '0;
         busy      <= 1'b0;
         ambient_q <= '0;
         light_q   <= '0;
      end else begin
         state <= state_nxt;

         if (take0 || take1) begin
            out_valid <= 1'b1;
            out_data  <= take0 ? req0_data : req1_data;
         end else if (out_xfer) begin
            out_valid <= 1'b0;
         end

         // Saturate both ends so a late transfer at max cannot wrap the count.
         case ({out_xfer, bm_xfer})
            2'b10:   if (inflight != INFLIGHT_MAX) inflight <= inflight + INFLIGHT_ONE;
            2'b01:   if (inflight != '0) inflight <= inflight - INFLIGHT_ONE;
            default: ;
         endcase

         if ((state == RUN) && cfg_we) begin
            busy      <= 1'b1;
            pend_sel  <= cfg_sel;
            pend_data <= cfg_data;
         end else if (state == UPDATE) begin
            busy <= 1'b0;
            if (pend_sel) light_q   <= pend_data;
            else          ambient_q <= pend_data;
         end
      end
   end

   assign dirpint_to_calc_direct_valid = out_valid;
   assign dirpint_to_calc_direct_data  = out_data;
   assign cfg_busy                     = busy;
   assign ambient                      = ambient_q;
   assign light_color                  = light_q;
endmodule

// File: tb/tb_calc_direct_arb.sv
// tb/tb_calc_direct_arb.sv - scoreboard bench for calc_direct_arb with a behavioural reference model
module tb_calc_direct_arb;
   localparam int W   = 2;
   localparam int MAX = 3;
`ifdef CDARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk, rst;
   logic        req0_valid, req1_valid, req0_stall, req1_stall;
   logic [31:0] req0_data, req1_data, out_data;
   logic        out_valid, ostall, bm_valid, bm_stall;
   logic        cfg_we, cfg_sel, cfg_busy;
   logic [95:0] cfg_data, ambient, light_color;

   calc_direct_arb #(.INFLIGHT_W(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_stall(req0_stall),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_stall(req1_stall),
      .dirpint_to_calc_direct_valid(out_valid), .dirpint_to_calc_direct_data(out_data),
      .dirpint_to_calc_direct_stall(ostall),
      .calc_direct_to_BM_valid(bm_valid), .calc_direct_to_BM_stall(bm_stall),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_busy(cfg_busy),
      .ambient(ambient), .light_color(light_color)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0, n_bad = 0;
   logic [31:0] src0[$], src1[$], exp_q[$], obs_q[$];
   bit          en0, en1;
   bit          last_stall0, last_stall1, last_busy;

   int          m_state, m_infl;
   bit          m_ov, m_last, m_busy, m_psel;
   logic [95:0] m_pdata, m_amb, m_light;

   localparam logic [95:0] ONE3 = {3{32'h3f80_0000}};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_infl = 0; m_ov = 0; m_last = 1; m_busy = 0; m_psel = 0;
      m_pdata = '0; m_amb = '0; m_light = '0;
      exp_q.delete(); src0.delete(); src1.delete();
   endtask

   // Drive one cycle, predict from the model, compare, then advance the model.
   task automatic tick();
      int g, nstate;
      bit can, xfer, bm;
      req0_valid = en0 && (src0.size() > 0);
      req0_data  = req0_valid ? src0[0] : $urandom;
      req1_valid = en1 && (src1.size() > 0);
      req1_data  = req1_valid ? src1[0] : $urandom;
      @(negedge clk);
      can = (m_state == 0) && (!m_ov || !ostall) && (m_infl != MAX);
      g = -1;
      if (can) begin
         if (req0_valid && req1_valid) g = RR ? (m_last ? 0 : 1) : 0;
         else if (req0_valid)          g = 0;
         else if (req1_valid)          g = 1;
      end
      last_stall0 = req0_stall; last_stall1 = req1_stall; last_busy = cfg_busy;
      chk("req0_stall", req0_stall, g != 0);
      chk("req1_stall", req1_stall, g != 1);
      chk("out_valid", out_valid, m_ov);
      chk("cfg_busy", cfg_busy, m_busy);
      chk("ambient", ambient, m_amb);
      chk("light_color", light_color, m_light);
      xfer = m_ov && !ostall;
      bm   = bm_valid && !bm_stall;
      if (g == 0) exp_q.push_back(req0_data);
      if (g == 1) exp_q.push_back(req1_data);
      nstate = m_state;
      case (m_state)
         0: if (cfg_we) begin nstate = 1; m_busy = 1; m_psel = cfg_sel; m_pdata = cfg_data; end
         1: if (!m_ov && m_infl == 0) nstate = 2;
         default: begin
            if (m_psel) m_light = m_pdata; else m_amb = m_pdata;
            m_busy = 0; nstate = 0;
         end
      endcase
      if (xfer && !bm && m_infl < MAX)   m_infl++;
      else if (!xfer && bm && m_infl > 0) m_infl--;
      if (g >= 0)    m_ov = 1;
      else if (xfer) m_ov = 0;
      if (g == 0) begin m_last = 0; void'(src0.pop_front()); end
      if (g == 1) begin m_last = 1; void'(src1.pop_front()); end
      m_state = nstate;
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int max);
      int k = 0;
      en0 = 1; en1 = 1; ostall = 0; bm_valid = 1; bm_stall = 0; cfg_we = 0;
      while ((src0.size() > 0 || src1.size() > 0 || m_ov || m_infl != 0 || m_state != 0) && k < max) begin
         tick(); k++;
      end
      chk("settle_timeout", k < max, 1'b1);
   endtask

   task automatic run_until_sent(input int max);
      int k = 0;
      while ((src0.size() > 0 || src1.size() > 0 || m_ov) && k < max) begin
         tick(); k++;
      end
      chk("send_timeout", k < max, 1'b1);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("out_unexpected", 1'b1, 1'b0);
         end else begin
            chk("out_data", out_data, exp_q[0]);
            if (!ostall) begin
               obs_q.push_back(out_data);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [31:0] ord[8];
      rst = 0; en0 = 0; en1 = 0; req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
      ostall = 0; bm_valid = 0; bm_stall = 0; cfg_we = 0; cfg_sel = 0; cfg_data = '0;
      model_reset();
      #12;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 32'h0);
      chk("rst_busy", cfg_busy, 1'b0);
      chk("rst_ambient", ambient, 96'h0);
      chk("rst_light", light_color, 96'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1;

      // Tie arbitration order
      obs_q.delete();
      for (int i = 0; i < 4; i++) begin
         src0.push_back(32'h01 + i);
         src1.push_back(32'h81 + i);
         ord[RR ? 2*i : i]     = 32'h01 + i;
         ord[RR ? 2*i + 1 : i + 4] = 32'h81 + i;
      end
      settle(40);
      chk("tie_count", obs_q.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < obs_q.size()) chk("tie_order", obs_q[i], ord[i]);

      // Output held under stall
      obs_q.delete();
      en0 = 1; en1 = 1; ostall = 1; bm_valid = 1;
      src0.push_back(32'hFF);
      tick();
      src0.push_back(32'h12); src1.push_back(32'h11);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_data", out_data, 32'hFF);
         chk("hold_stall0", last_stall0, 1'b1);
         chk("hold_stall1", last_stall1, 1'b1);
      end
      ostall = 0;
      tick();
      chk("hold_one_xfer", obs_q.size(), 1);
      if (obs_q.size() > 0) chk("hold_xfer_data", obs_q[0], 32'hFF);
      settle(40);

      // In-flight limit
      bm_valid = 0; en0 = 1;
      for (int i = 0; i < 3; i++) begin
         src0.push_back(32'h40 + i);
         run_until_sent(10);
      end
      src0.push_back(32'h44);
      tick(); tick();
      chk("fourth_blocked", last_stall0, 1'b1);
      bm_valid = 1; tick(); bm_valid = 0;
      chk("fourth_blocked_bm", last_stall0, 1'b1);
      tick();
      chk("fourth_granted", last_stall0, 1'b0);
      settle(40);

      // Config write waits for drain; second write while busy is ignored
      bm_valid = 0; en0 = 1;
      src0.push_back(32'h51); src0.push_back(32'h52);
      run_until_sent(10);
      cfg_we = 1; cfg_sel = 0; cfg_data = ONE3;
      tick();
      cfg_we = 0;
      src0.push_back(32'h53);
      tick();
      chk("cfg_busy_set", last_busy, 1'b1);
      chk("drain_blocks", last_stall0, 1'b1);
      cfg_we = 1; cfg_sel = 1; cfg_data = 96'h1234_5678_9abc_def0_1357_9bdf;
      tick();
      cfg_we = 0;
      bm_valid = 1; tick(); bm_valid = 0;
      tick(); tick();
      chk("ambient_held", ambient, 96'h0);
      bm_valid = 1; tick(); bm_valid = 0;
      repeat (4) tick();
      chk("ambient_written", ambient, ONE3);
      chk("light_untouched", light_color, 96'h0);
      chk("cfg_busy_clear", cfg_busy, 1'b0);
      settle(40);

      // Randomised traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0 && src0.size() < 4) src0.push_back($urandom);
         if ($urandom_range(3) == 0 && src1.size() < 4) src1.push_back($urandom);
         en0 = ($urandom_range(3) != 0);
         en1 = ($urandom_range(3) != 0);
         ostall   = ($urandom_range(9) < 3);
         bm_valid = $urandom_range(1);
         bm_stall = ($urandom_range(4) == 0);
         cfg_we   = ($urandom_range(29) == 0);
         cfg_sel  = $urandom_range(1);
         cfg_data = {$urandom, $urandom, $urandom};
         tick();
      end
      cfg_we = 0;
      settle(200);

      // Reset mid-stream with output pending and config queued
      en0 = 1; en1 = 1; ostall = 1; bm_valid = 0;
      src0.push_back(32'h71); src1.push_back(32'h72);
      cfg_we = 1; cfg_sel = 0; cfg_data = {$urandom, $urandom, $urandom};
      tick();
      cfg_we = 0;
      tick();
      rst = 0;
      #2;
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_data", out_data, 32'h0);
      chk("midrst_busy", cfg_busy, 1'b0);
      chk("midrst_ambient", ambient, 96'h0);
      chk("midrst_light", light_color, 96'h0);
      model_reset();
      ostall = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
      obs_q.delete();
      src0.push_back(32'hA0); src1.push_back(32'hB0);
      tick(); tick();
      chk("post_rst_first", (obs_q.size() > 0) ? obs_q[0] : 32'h0, 32'hA0);
      settle(40);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
